// File: rtl/relu_requant_pack_pkg.sv
// Shared constants, pipeline stage records and the rounding/saturation helpers
// for the ReLU / requantise / byte-pack output stage.
package relu_requant_pkg;

    localparam int IN_W  = 35;
    localparam int OUT_W = 8;
    localparam int LANES = 4;
    localparam int SH_W  = 5;
    localparam int ACC_W = IN_W + 1;

    typedef logic [LANES-1:0][SH_W-1:0] shift_tbl_t;

    localparam shift_tbl_t SHIFT_TBL = {5'd16, 5'd16, 5'd16, 5'd16};

    typedef struct packed {
        logic             valid;
        logic [ACC_W-1:0] data;
        logic [SH_W-1:0]  sh;
        logic             last;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic [OUT_W-1:0] data;
        logic             last;
    } s2_t;

    // Half-LSB of the post-shift result, so the shift rounds half up.
    function automatic logic [ACC_W-1:0] round_bias(input logic [SH_W-1:0] sh);
        if (sh == 5'd0) begin
            return '0;
        end else begin
            return {{(ACC_W-1){1'b0}}, 1'b1} << (sh - 5'd1);
        end
    endfunction

    function automatic logic [OUT_W-1:0] sat_u8(input logic [ACC_W-1:0] q);
        if (|q[ACC_W-1:OUT_W]) begin
            return 8'hFF;
        end else begin
            return q[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/relu_requant_pack_if.sv
// Input sample stream and packed output word stream, both valid/ready.
interface relu_requant_pack_if;
    import relu_requant_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [IN_W-1:0]        in_data;
    logic [1:0]             in_ch;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       out_keep;
    logic                   out_last;

    modport master (
        output in_valid, in_data, in_ch, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        input  in_valid, in_data, in_ch, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );

endinterface

// File: rtl/relu_requant_pack_byte_packer.sv
// Collects saturated bytes into LANES-wide words; flushes early on a last byte.
module byte_packer
    import relu_requant_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   adv_i,
    input  logic                   byte_valid_i,
    input  logic [OUT_W-1:0]       byte_i,
    input  logic                   last_i,
    output logic                   out_valid_o,
    output logic [LANES*OUT_W-1:0] out_data_o,
    output logic [LANES-1:0]       out_keep_o,
    output logic                   out_last_o
);

    logic [1:0]             cnt_q, cnt_d;
    logic [LANES*OUT_W-1:0] build_q, build_d, word_s;
    logic [LANES*OUT_W-1:0] data_q, data_d;
    logic [LANES-1:0]       keep_q, keep_d, keep_s;
    logic                   last_q, last_d;
    logic                   valid_q, valid_d;

    // Lane write, word completion and output-register next state.
    always_comb begin
        word_s = build_q;
        word_s[{cnt_q, 3'b000} +: OUT_W] = byte_i;
        case (cnt_q)
            2'd0:    keep_s = 4'b0001;
            2'd1:    keep_s = 4'b0011;
            2'd2:    keep_s = 4'b0111;
            2'd3:    keep_s = 4'b1111;
            default: keep_s = 4'b1111;
        endcase
        cnt_d   = cnt_q;
        build_d = build_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q;
        // A completed word and the handoff of the previous one share the same cycle.
        if (adv_i) begin
            valid_d = 1'b0;
            if (byte_valid_i) begin
                if ((cnt_q == 2'd3) || last_i) begin
                    valid_d = 1'b1;
                    data_d  = word_s;
                    keep_d  = keep_s;
                    last_d  = last_i;
                    cnt_d   = 2'd0;
                    build_d = '0;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    build_d = word_s;
                end
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            build_q <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            build_q <= build_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_keep_o  = keep_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/relu_requant_pack.sv
// ReLU, per-channel rounding shift and uint8 saturation over two register
// stages, followed by the byte packer; one global advance stalls everything.
module relu_requant_pack
    import relu_requant_pkg::*;
#(
    parameter shift_tbl_t SHIFT_TBL_P = SHIFT_TBL
)
(
    input  logic               clk,
    input  logic               rst_n,
    relu_requant_pack_if.slave bus
);

    s1_t             s1_q, s1_d;
    s2_t             s2_q, s2_d;
    logic            adv_s;
    logic            pk_valid_s;
    logic [ACC_W-1:0] r_s;
    logic [SH_W-1:0] sh_s;

    assign adv_s        = !(pk_valid_s && !bus.out_ready);
    assign bus.in_ready = adv_s && rst_n;
    assign bus.out_valid = pk_valid_s;

    // S1 computes ReLU plus rounding offset; S2 shifts and saturates.
    always_comb begin
        sh_s = SHIFT_TBL_P[bus.in_ch];
        if (bus.in_data[IN_W-1]) begin
            r_s = '0;
        end else begin
            r_s = {1'b0, bus.in_data};
        end
        s1_d.valid = bus.in_valid;
        s1_d.data  = r_s + round_bias(sh_s);
        s1_d.sh    = sh_s;
        s1_d.last  = bus.in_last;
        s2_d.valid = s1_q.valid;
        s2_d.data  = sat_u8(s1_q.data >> s1_q.sh);
        s2_d.last  = s1_q.last;
    end

    // Pipeline stage registers, held while the output word is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (adv_s) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end else begin
            s1_q <= s1_q;
            s2_q <= s2_q;
        end
    end

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .adv_i        (adv_s),
        .byte_valid_i (s2_q.valid),
        .byte_i       (s2_q.data),
        .last_i       (s2_q.last),
        .out_valid_o  (pk_valid_s),
        .out_data_o   (bus.out_data),
        .out_keep_o   (bus.out_keep),
        .out_last_o   (bus.out_last)
    );

endmodule

// File: tb/tb_relu_requant_pack.sv
// Bench for relu_requant_pack: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the whole transform.
module tb_relu_requant_pack;
    import relu_requant_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    relu_requant_pack_if bus ();
    relu_requant_pack_if bus2 ();

    relu_requant_pack u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    relu_requant_pack #(.SHIFT_TBL_P({5'd16, 5'd8, 5'd4, 5'd0}))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    word_t exp_q[$];
    word_t got_q[$];
    word_t got2_q[$];
    int tests_run = 0;
    int fails = 0;
    int rdy_mode = 0;
    logic [31:0] part = 32'h0;
    int pcnt = 0;

    function automatic logic [7:0] ref_byte(input logic [34:0] d, input int sh);
        longint v;
        v = longint'($signed(d));
        if (v < 0) return 8'h00;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >> sh;
        if (v > 255) return 8'hFF;
        return v[7:0];
    endfunction

    // Reference model (main instance) and output collection, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                part = 32'h0;
                pcnt = 0;
            end else begin
                if (bus.in_valid && bus.in_ready) begin
                    part[pcnt*8 +: 8] = ref_byte(bus.in_data, 16);
                    pcnt++;
                    if (pcnt == 4 || bus.in_last) begin
                        exp_q.push_back({part, 4'((1 << pcnt) - 1), bus.in_last});
                        part = 32'h0;
                        pcnt = 0;
                    end
                end
                if (bus.out_valid && bus.out_ready)
                    got_q.push_back({bus.out_data, bus.out_keep, bus.out_last});
                if (bus2.out_valid && bus2.out_ready)
                    got2_q.push_back({bus2.out_data, bus2.out_keep, bus2.out_last});
            end
        end
    end

    // Consumer ready: always, 1-0-0-1 pattern, or random.
    initial begin
        int phase;
        logic [3:0] pat;
        phase = 0;
        pat = 4'b1001;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin bus.out_ready = pat[phase % 4]; phase++; end
                2: bus.out_ready = 1'($urandom_range(0, 1));
                default: begin bus.out_ready = 1'b1; phase = 0; end
            endcase
        end
    end

    task automatic send(input bit sec, input logic [34:0] d, input logic [1:0] ch, input logic last);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        if (sec) begin
            bus2.in_valid = 1'b1; bus2.in_data = d; bus2.in_ch = ch; bus2.in_last = last;
        end else begin
            bus.in_valid = 1'b1; bus.in_data = d; bus.in_ch = ch; bus.in_last = last;
        end
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = sec ? (bus2.in_ready === 1'b1) : (bus.in_ready === 1'b1);
            n++;
        end
        if (!ok) begin
            tests_run++;
            fails++;
            $display("FAIL send_timeout: in_ready never high for data %h", d);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int c;
        c = 0;
        while (got_q.size() < n && c < 300) begin
            @(posedge clk);
            c++;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 35'h20000;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
            tests_run++;
            if (bus.out_keep !== 4'b0000) begin fails++; $display("FAIL reset_keep: got %b want 0000", bus.out_keep); end
            tests_run++;
            if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
        repeat (8) @(posedge clk);
        #1;
        tests_run++;
        if (got_q.size() != 0) begin fails++; $display("FAIL reset_no_words: got %0d words want 0", got_q.size()); end
    endtask

    task automatic test_relu_round();
        got_q.delete();
        send(1'b0, 35'h7FFFFFFFB, 2'd0, 1'b0);
        send(1'b0, 35'h000008000, 2'd1, 1'b0);
        send(1'b0, 35'h000017FFF, 2'd2, 1'b0);
        send(1'b0, 35'h001000000, 2'd3, 1'b0);
        wait_words(1);
        tests_run++;
        if (got_q.size() != 1) begin fails++; $display("FAIL relu_count: got %0d words want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            tests_run++;
            if (got_q[0] !== {32'hFF010100, 4'b1111, 1'b0}) begin
                fails++;
                $display("FAIL relu_word: got %h/%b/%b want ff010100/1111/0", got_q[0].data, got_q[0].keep, got_q[0].last);
            end
        end
    endtask

    task automatic test_partial_flush();
        got_q.delete();
        for (int i = 0; i < 6; i++) send(1'b0, 35'h20000, 2'd0, (i == 5));
        wait_words(2);
        tests_run++;
        if (got_q.size() != 2) begin fails++; $display("FAIL partial_count: got %0d words want 2", got_q.size()); end
        if (got_q.size() > 1) begin
            tests_run++;
            if (got_q[0] !== {32'h02020202, 4'b1111, 1'b0}) begin
                fails++;
                $display("FAIL partial_word1: got %h/%b/%b want 02020202/1111/0", got_q[0].data, got_q[0].keep, got_q[0].last);
            end
            tests_run++;
            if (got_q[1] !== {32'h00000202, 4'b0011, 1'b1}) begin
                fails++;
                $display("FAIL partial_word2: got %h/%b/%b want 00000202/0011/1", got_q[1].data, got_q[1].keep, got_q[1].last);
            end
        end
    endtask

    task automatic test_backpressure();
        int nstall;
        got_q.delete();
        nstall = 0;
        rdy_mode = 1;
        fork
            begin
                for (int k = 0; k < 12; k++) send(1'b0, 35'((k + 1) << 16), 2'd0, (k == 11));
            end
            begin
                logic [31:0] prev_d;
                bit prev_stall;
                prev_stall = 1'b0;
                prev_d = 32'h0;
                repeat (80) begin
                    @(negedge clk);
                    if (prev_stall) begin
                        tests_run++;
                        if (bus.out_data !== prev_d || bus.out_valid !== 1'b1) begin
                            fails++;
                            $display("FAIL stall_hold: got %h/%b want %h/1", bus.out_data, bus.out_valid, prev_d);
                        end
                    end
                    if (bus.out_valid && !bus.out_ready) begin
                        nstall++;
                        tests_run++;
                        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
                    end
                    prev_stall = bus.out_valid && !bus.out_ready;
                    prev_d = bus.out_data;
                end
            end
        join
        wait_words(3);
        rdy_mode = 0;
        tests_run++;
        if (nstall == 0) begin fails++; $display("FAIL stall_seen: got 0 stall cycles want >0"); end
        tests_run++;
        if (got_q.size() != 3) begin fails++; $display("FAIL bp_count: got %0d words want 3", got_q.size()); end
        for (int w = 0; w < got_q.size() && w < 3; w++) begin
            logic [31:0] ew;
            for (int b = 0; b < 4; b++) ew[b*8 +: 8] = 8'(4 * w + b + 1);
            tests_run++;
            if (got_q[w] !== {ew, 4'b1111, (w == 2)}) begin
                fails++;
                $display("FAIL bp_word%0d: got %h/%b/%b want %h/1111/%0d", w, got_q[w].data, got_q[w].keep, got_q[w].last, ew, (w == 2));
            end
        end
    endtask

    task automatic test_per_channel();
        logic [31:0] mw;
        got2_q.delete();
        for (int c = 0; c < 4; c++) send(1'b1, 35'h100, 2'(c), (c == 3));
        repeat (10) @(posedge clk);
        #1;
        mw = {ref_byte(35'h100, 16), ref_byte(35'h100, 8), ref_byte(35'h100, 4), ref_byte(35'h100, 0)};
        tests_run++;
        if (got2_q.size() != 1) begin fails++; $display("FAIL chan_count: got %0d words want 1", got2_q.size()); end
        if (got2_q.size() > 0) begin
            tests_run++;
            if (got2_q[0] !== {32'h000110FF, 4'b1111, 1'b1}) begin
                fails++;
                $display("FAIL chan_word: got %h/%b/%b want 000110ff/1111/1", got2_q[0].data, got2_q[0].keep, got2_q[0].last);
            end
            tests_run++;
            if (got2_q[0].data !== mw) begin fails++; $display("FAIL chan_model: got %h want %h", got2_q[0].data, mw); end
        end
    endtask

    task automatic test_reset_midword();
        got_q.delete();
        send(1'b0, 35'h30000, 2'd0, 1'b0);
        send(1'b0, 35'h30000, 2'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) send(1'b0, 35'((k + 4) << 16), 2'd0, 1'b0);
        wait_words(1);
        tests_run++;
        if (got_q.size() != 1) begin fails++; $display("FAIL rstmid_count: got %0d words want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            tests_run++;
            if (got_q[0] !== {32'h07060504, 4'b1111, 1'b0}) begin
                fails++;
                $display("FAIL rstmid_word: got %h/%b/%b want 07060504/1111/0", got_q[0].data, got_q[0].keep, got_q[0].last);
            end
        end
    endtask

    task automatic test_random();
        logic [34:0] d;
        got_q.delete();
        exp_q.delete();
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: d = {3'b111, $urandom};
                1: d = 35'($urandom_range(0, 32'h00FF_FFFF));
                2: d = {3'b000, $urandom};
                default: d = 35'($urandom_range(0, 32'h0002_0000));
            endcase
            send(1'b0, d, 2'($urandom_range(0, 3)), (i == 59) || ($urandom_range(0, 5) == 0));
        end
        wait_words(exp_q.size());
        rdy_mode = 0;
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rand_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL rand_word%0d: got %h/%b/%b want %h/%b/%b", i, got_q[i].data, got_q[i].keep,
                         got_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ch = 2'd0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_ch = 2'd0; bus2.in_last = 1'b0; bus2.out_ready = 1'b1;
        test_reset();
        test_relu_round();
        test_partial_flush();
        test_backpressure();
        test_per_channel();
        test_reset_midword();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
